// File: rtl/img_stream_source_if.sv
`default_nettype none
// ============================================================================
// Module      : img_stream_source_if
// Description : Frame-load write port, stream control and pixel output bundle
//               for img_stream_source.
// Revision    : 1.0 - initial release
// ============================================================================
interface img_stream_source_if #(
    parameter int DATAWIDTH  = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  WR_EN;
    logic [ADDR_WIDTH-1:0] WR_ADDR;
    logic [DATAWIDTH-1:0]  WR_DATA;
    logic                  Start;
    logic                  Stall;
    logic [DATAWIDTH-1:0]  Out;
    logic                  Valid_OUT;
    logic                  Busy;
    logic                  Done;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, Start, Stall,
        input  Out, Valid_OUT, Busy, Done
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, Start, Stall,
        output Out, Valid_OUT, Busy, Done
    );
endinterface
`default_nettype wire

// File: rtl/img_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : img_stream_source
// Description : Raster-order frame transmitter with trailing zero flush.
//               Optional macro IMG_SRC_REPEAT_EN: back-to-back frames when
//               Start is held at the end of the flush.
// Revision    : 1.0 - initial release
// ============================================================================
module img_stream_source #(
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4,
    parameter int DATAWIDTH  = 32,
    parameter int FLUSH_LEN  = IMG_WIDTH + 1,
    parameter int ADDR_WIDTH = 16
) (
    input  wire logic          CLK,
    input  wire logic          CLR,
    img_stream_source_if.slave bus
);
    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;

    localparam logic [IDX_W-1:0]    FIRST_IDX = '0;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0]    FLUSH_END = CNT_W'(FLUSH_LEN);
    localparam logic [ADDR_WIDTH:0] N_EXT     = (ADDR_WIDTH + 1)'(N);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [DATAWIDTH-1:0] mem [N];

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 relaunch;
    logic                 flush_end;

`ifdef IMG_SRC_REPEAT_EN
    assign relaunch = bus.Start;
`else
    assign relaunch = 1'b0;
`endif

    // FLUSH with the counter at its limit is the cycle showing the final beat
    assign flush_end = (state_q == S_FLUSH) && (cnt_q == FLUSH_END);

    always_ff @(posedge CLK) begin
        if (!CLR && bus.WR_EN && (state_q == S_IDLE) && ({1'b0, bus.WR_ADDR} < N_EXT)) begin
            mem[bus.WR_ADDR[IDX_W-1:0]] <= bus.WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Launching a frame issues pixel 0 on the same edge, so the pointer resumes at 1
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = (N == 1) ? S_FLUSH : S_STREAM;
                    ptr_d   = IDX_W'(1);
                    cnt_d   = '0;
                end
            end
            S_STREAM: begin
                if (!bus.Stall) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d = S_FLUSH;
                        ptr_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (flush_end) begin
                    if (relaunch) begin
                        state_d = (N == 1) ? S_FLUSH : S_STREAM;
                        ptr_d   = IDX_W'(1);
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (!bus.Stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    out_d   = mem[FIRST_IDX];
                    valid_d = 1'b1;
                end
            end
            S_STREAM: begin
                if (!bus.Stall) begin
                    out_d   = mem[ptr_q];
                    valid_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_end) begin
                    done_d = 1'b1;
                    if (relaunch) begin
                        out_d   = mem[FIRST_IDX];
                        valid_d = 1'b1;
                    end
                end else if (!bus.Stall) begin
                    out_d   = '0;
                    valid_d = 1'b1;
                end
            end
            default: begin
                out_d = out_q;
            end
        endcase
    end

    assign bus.Out       = out_q;
    assign bus.Valid_OUT = valid_q;
    assign bus.Done      = done_q;
    assign bus.Busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire
